// File: rtl/ann_pkg.sv
// Shared definitions for the layer scheduler: Q7.24 format, FSM states and
// weight-bank field selectors.
package ann_pkg;

  localparam int unsigned Q_DWIDTH = 32;
  localparam int unsigned Q_FRAC   = 24;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StEmit
  } sched_state_e;

  localparam logic [1:0] CFG_SEL_WA   = 2'd0;
  localparam logic [1:0] CFG_SEL_WB   = 2'd1;
  localparam logic [1:0] CFG_SEL_BIAS = 2'd2;
  localparam logic [1:0] CFG_SEL_RSVD = 2'd3;

endpackage

// File: rtl/perceptron_wbank.sv
// Per-neuron weight bank {wa, wb, bias}: one write port, one combinational
// read port.
module perceptron_wbank
  import ann_pkg::*;
#(
  parameter int unsigned DWIDTH  = Q_DWIDTH,
  parameter int unsigned NEURONS = 4,
  parameter int unsigned NIDX    = $clog2(NEURONS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [NIDX-1:0]   i_waddr,
  input  logic [1:0]        i_wsel,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic [NIDX-1:0]   i_raddr,
  output logic [DWIDTH-1:0] o_wa,
  output logic [DWIDTH-1:0] o_wb,
  output logic [DWIDTH-1:0] o_bias
);

  logic [DWIDTH-1:0] r_wa   [NEURONS];
  logic [DWIDTH-1:0] r_wb   [NEURONS];
  logic [DWIDTH-1:0] r_bias [NEURONS];

  logic w_waddr_ok;
  logic w_raddr_ok;

  // Only matters when NEURONS is not a power of two.
  assign w_waddr_ok = (32'(i_waddr) < NEURONS);
  assign w_raddr_ok = (32'(i_raddr) < NEURONS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NEURONS; i++) begin
        r_wa[i]   <= '0;
        r_wb[i]   <= '0;
        r_bias[i] <= '0;
      end
    end else if (i_we && w_waddr_ok) begin
      case (i_wsel)
        CFG_SEL_WA:   r_wa[i_waddr]   <= i_wdata;
        CFG_SEL_WB:   r_wb[i_waddr]   <= i_wdata;
        CFG_SEL_BIAS: r_bias[i_waddr] <= i_wdata;
        default: ;
      endcase
    end
  end

  assign o_wa   = w_raddr_ok ? r_wa[i_raddr]   : '0;
  assign o_wb   = w_raddr_ok ? r_wb[i_raddr]   : '0;
  assign o_bias = w_raddr_ok ? r_bias[i_raddr] : '0;

endmodule

// File: rtl/perceptron_sched.sv
// Time-multiplexes one shared perceptron across NEURONS logical neurons: one
// input pair per pass, results streamed out in neuron index order.
module perceptron_sched
  import ann_pkg::*;
#(
  parameter int unsigned DWIDTH  = Q_DWIDTH,
  parameter int unsigned NEURONS = 4,
  parameter int unsigned NIDX    = $clog2(NEURONS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cfg_we,
  input  logic [NIDX-1:0]   i_cfg_addr,
  input  logic [1:0]        i_cfg_sel,
  input  logic [DWIDTH-1:0] i_cfg_data,
  output logic              o_cfg_err,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DWIDTH-1:0] i_in_a,
  input  logic [DWIDTH-1:0] i_in_b,
  output logic [DWIDTH-1:0] o_p_a,
  output logic [DWIDTH-1:0] o_p_b,
  output logic [DWIDTH-1:0] o_p_wa,
  output logic [DWIDTH-1:0] o_p_wb,
  output logic [DWIDTH-1:0] o_p_bias,
  input  logic [DWIDTH-1:0] i_p_out,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DWIDTH-1:0] o_out_data,
  output logic [NIDX-1:0]   o_out_idx,
  output logic              o_out_last,
  output logic              o_busy
);

  localparam logic [NIDX-1:0] LastIdx = NIDX'(NEURONS - 1);

  sched_state_e      r_state;
  logic [NIDX-1:0]   r_idx;
  logic [DWIDTH-1:0] r_p_a, r_p_b, r_p_wa, r_p_wb, r_p_bias;
  logic              r_out_valid;
  logic [DWIDTH-1:0] r_out_data;
  logic [NIDX-1:0]   r_out_idx;
  logic              r_out_last;
  logic              r_cfg_err;

  logic              w_busy;
  logic              w_accept;
  logic              w_cfg_ok;
  logic              w_cfg_drop;
  logic [NIDX-1:0]   w_rd_idx;
  logic [DWIDTH-1:0] w_bank_wa, w_bank_wb, w_bank_bias;
  logic [DWIDTH-1:0] w_next_wa, w_next_wb, w_next_bias;

  assign w_busy     = (r_state != StIdle);
  assign o_in_ready = rst_n && !w_busy;
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_cfg_ok   = i_cfg_we && !w_busy && (i_cfg_sel != CFG_SEL_RSVD);
  assign w_cfg_drop = i_cfg_we && !w_cfg_ok;

  // Bank entry that will be loaded onto p_* at the next transition into ISSUE.
  assign w_rd_idx = w_busy ? (r_idx + NIDX'(1)) : '0;

  perceptron_wbank #(
    .DWIDTH  (DWIDTH),
    .NEURONS (NEURONS),
    .NIDX    (NIDX)
  ) u_wbank (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_cfg_ok),
    .i_waddr (i_cfg_addr),
    .i_wsel  (i_cfg_sel),
    .i_wdata (i_cfg_data),
    .i_raddr (w_rd_idx),
    .o_wa    (w_bank_wa),
    .o_wb    (w_bank_wb),
    .o_bias  (w_bank_bias)
  );

  // Forward a write landing on the same edge as the accept into the first issue.
  always_comb begin
    w_next_wa   = w_bank_wa;
    w_next_wb   = w_bank_wb;
    w_next_bias = w_bank_bias;
    if (w_cfg_ok && (i_cfg_addr == w_rd_idx)) begin
      case (i_cfg_sel)
        CFG_SEL_WA:   w_next_wa   = i_cfg_data;
        CFG_SEL_WB:   w_next_wb   = i_cfg_data;
        CFG_SEL_BIAS: w_next_bias = i_cfg_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_p_a       <= '0;
      r_p_b       <= '0;
      r_p_wa      <= '0;
      r_p_wb      <= '0;
      r_p_bias    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_drop;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_p_a    <= i_in_a;
            r_p_b    <= i_in_b;
            r_p_wa   <= w_next_wa;
            r_p_wb   <= w_next_wb;
            r_p_bias <= w_next_bias;
            r_idx    <= '0;
            r_state  <= StIssue;
          end
        end
        StIssue: begin
          r_state <= StCapture;
        end
        StCapture: begin
          r_out_data  <= i_p_out;
          r_out_idx   <= r_idx;
          r_out_last  <= (r_idx == LastIdx);
          r_out_valid <= 1'b1;
          r_state     <= StEmit;
        end
        StEmit: begin
          if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
            if (r_idx == LastIdx) begin
              r_state <= StIdle;
            end else begin
              r_idx    <= w_rd_idx;
              r_p_wa   <= w_next_wa;
              r_p_wb   <= w_next_wb;
              r_p_bias <= w_next_bias;
              r_state  <= StIssue;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_p_a       = r_p_a;
  assign o_p_b       = r_p_b;
  assign o_p_wa      = r_p_wa;
  assign o_p_wb      = r_p_wb;
  assign o_p_bias    = r_p_bias;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_idx   = r_out_idx;
  assign o_out_last  = r_out_last;
  assign o_cfg_err   = r_cfg_err;
  assign o_busy      = w_busy;

endmodule
